// File: rtl/aq_mmu_tlbram_ctrl_pkg.sv
// Shared definitions for the MMU TLB SRAM access controller.
//   ADDR_WIDTH / DATA_WIDTH : TLB entry index and entry widths (64 x 88).
//   VLD_BIT                 : position of the per-entry valid flag.
//   tlb_state_e             : controller FSM encoding (IDLE / INV).
//   SWEEP_WEN               : active-low bit write enable used by the sweep,
//                             enabling only the valid flag.
package aq_mmu_tlbram_ctrl_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 88;
  localparam int VLD_BIT    = 87;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INV  = 1'b1
  } tlb_state_e;

  localparam logic [DATA_WIDTH-1:0] SWEEP_WEN = ~(DATA_WIDTH'(1) << VLD_BIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

endpackage

// File: rtl/aq_mmu_tlbram_ctrl.sv
// Single-port TLB SRAM access controller.
// Arbitrates the SRAM's one port between an invalidate-all sweep (highest
// priority), refill writes and lookup reads, and drives the SRAM's active-low
// controls. Read data comes straight from sram_q, valid one cycle after grant.
// Ports:
//   forever_cpuclk, cpurst_b            : clock, async active-low reset
//   rd_req/rd_idx/rd_gnt                : lookup read request / index / grant
//   rd_data_vld/rd_data                 : read return, one cycle after grant
//   wr_req/wr_idx/wr_data/wr_mask/wr_gnt: refill write with per-bit mask
//   inv_all_req/inv_busy/inv_done       : invalidate-all pulse / busy / done
//   sram_a/cen/gwen/wen/d, sram_q       : SRAM macro interface
module aq_mmu_tlbram_ctrl
  import aq_mmu_tlbram_ctrl_pkg::*;
(
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_gnt,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  input  logic                  inv_all_req,
  output logic                  inv_busy,
  output logic                  inv_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  tlb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_data_vld_q, rd_data_vld_d;
  logic                  inv_done_q, inv_done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_done_d = 1'b0;
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    sram_cen   = 1'b1;
    sram_gwen  = 1'b1;
    sram_wen   = '1;
    sram_a     = '0;
    sram_d     = '0;

    case (state_q)
      ST_INV: begin
        // Sweep owns the port; a repeated inv_all_req is simply not looked at.
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_a    = cnt_q;
        sram_wen  = SWEEP_WEN;
        // Wraps 63 -> 0 together with the return to IDLE.
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          inv_done_d = 1'b1;
        end
      end
      default: begin
        // Counter held at 0 in IDLE so the sweep always starts at entry 0.
        cnt_d = '0;
        if (inv_all_req) begin
          state_d = ST_INV;
        end
        // The cycle that requests the sweep still serves a normal access.
        if (wr_req) begin
          wr_gnt    = 1'b1;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_a    = wr_idx;
          sram_d    = wr_data;
          sram_wen  = ~wr_mask;
        end else if (rd_req) begin
          rd_gnt    = 1'b1;
          sram_cen  = 1'b0;
          sram_a    = rd_idx;
        end
      end
    endcase

    rd_data_vld_d = rd_gnt;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rd_data_vld_q <= 1'b0;
      inv_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_data_vld_q <= rd_data_vld_d;
      inv_done_q    <= inv_done_d;
    end
  end

  assign rd_data_vld = rd_data_vld_q;
  assign rd_data     = sram_q;
  assign inv_busy    = (state_q == ST_INV);
  assign inv_done    = inv_done_q;

endmodule

// File: tb/tb_aq_mmu_tlbram_ctrl.sv
// Directed bench for aq_mmu_tlbram_ctrl with a behavioural 64x88 SRAM.
module tb_aq_mmu_tlbram_ctrl;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b = 1'b1;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_idx = '0;
  logic        rd_gnt;
  logic        rd_data_vld;
  logic [87:0] rd_data;
  logic        wr_req = 1'b0;
  logic [5:0]  wr_idx = '0;
  logic [87:0] wr_data = '0;
  logic [87:0] wr_mask = '0;
  logic        wr_gnt;
  logic        inv_all_req = 1'b0;
  logic        inv_busy;
  logic        inv_done;
  logic [5:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [87:0] sram_wen;
  logic [87:0] sram_d;
  logic [87:0] sram_q = '0;

  logic [87:0] mem [64];

  int total = 0;
  int bad   = 0;

  localparam logic [87:0] ONES  = {88{1'b1}};
  localparam logic [87:0] A5    = {11{8'hA5}};
  localparam logic [87:0] PAT3  = 88'h123456789ABCDEF0123456;
  localparam logic [87:0] PART  = {{80{1'b1}}, 8'h00};
  localparam logic [87:0] INVE  = {1'b0, {87{1'b1}}};
  localparam logic [87:0] SWEN  = {1'b0, {87{1'b1}}};

  always #5 forever_cpuclk = ~forever_cpuclk;

  aq_mmu_tlbram_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .rd_gnt         (rd_gnt),
    .rd_data_vld    (rd_data_vld),
    .rd_data        (rd_data),
    .wr_req         (wr_req),
    .wr_idx         (wr_idx),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_gnt         (wr_gnt),
    .inv_all_req    (inv_all_req),
    .inv_busy       (inv_busy),
    .inv_done       (inv_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural SRAM: active-low enables, bit-masked write, 1-cycle read.
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else
        sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic do_wr(input logic [5:0] idx, input logic [87:0] d, input logic [87:0] m);
    wr_req = 1'b1; wr_idx = idx; wr_data = d; wr_mask = m;
    @(negedge forever_cpuclk);
    chk("wr_gnt", {87'd0, wr_gnt}, 88'd1);
    cyc();
    wr_req = 1'b0;
  endtask

  task automatic do_rd(input logic [5:0] idx, input logic [87:0] exp);
    rd_req = 1'b1; rd_idx = idx;
    @(negedge forever_cpuclk);
    chk("rd_gnt", {87'd0, rd_gnt}, 88'd1);
    cyc();
    rd_req = 1'b0;
    @(negedge forever_cpuclk);
    chk("rd_vld", {87'd0, rd_data_vld}, 88'd1);
    chk($sformatf("rd_data[%0d]", idx), rd_data, exp);
    cyc();
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 64; i++) do_wr(6'(i), ONES, ONES);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 cpurst_b = 1'b0;
    repeat (2) @(posedge forever_cpuclk);
    @(negedge forever_cpuclk);
    chk("rst_cen",   {87'd0, sram_cen},    88'd1);
    chk("rst_gwen",  {87'd0, sram_gwen},   88'd1);
    chk("rst_rdgnt", {87'd0, rd_gnt},      88'd0);
    chk("rst_wrgnt", {87'd0, wr_gnt},      88'd0);
    chk("rst_busy",  {87'd0, inv_busy},    88'd0);
    chk("rst_done",  {87'd0, inv_done},    88'd0);
    chk("rst_vld",   {87'd0, rd_data_vld}, 88'd0);
    cyc();
    cpurst_b = 1'b1;
    cyc();

    fill_ones();

    // Write idx 5 then read it back
    wr_req = 1'b1; wr_idx = 6'd5; wr_data = A5; wr_mask = ONES;
    @(negedge forever_cpuclk);
    chk("w5_gnt",  {87'd0, wr_gnt},    88'd1);
    chk("w5_cen",  {87'd0, sram_cen},  88'd0);
    chk("w5_gwen", {87'd0, sram_gwen}, 88'd0);
    chk("w5_a",    {82'd0, sram_a},    88'd5);
    chk("w5_wen",  sram_wen,           88'd0);
    chk("w5_d",    sram_d,             A5);
    cyc();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_idx = 6'd5;
    @(negedge forever_cpuclk);
    chk("r5_gnt",  {87'd0, rd_gnt},    88'd1);
    chk("r5_gwen", {87'd0, sram_gwen}, 88'd1);
    chk("r5_a",    {82'd0, sram_a},    88'd5);
    chk("r5_wen",  sram_wen,           ONES);
    cyc();
    rd_req = 1'b0;
    @(negedge forever_cpuclk);
    chk("r5_vld",  {87'd0, rd_data_vld}, 88'd1);
    chk("r5_data", rd_data,              A5);
    // Idle port
    chk("idle_cen", {87'd0, sram_cen}, 88'd1);
    chk("idle_a",   {82'd0, sram_a},   88'd0);
    chk("idle_d",   sram_d,            88'd0);
    cyc();
    @(negedge forever_cpuclk);
    chk("idle_vld", {87'd0, rd_data_vld}, 88'd0);
    cyc();

    // Simultaneous read and write to idx 3: write wins, read follows
    wr_req = 1'b1; wr_idx = 6'd3; wr_data = PAT3; wr_mask = ONES;
    rd_req = 1'b1; rd_idx = 6'd3;
    @(negedge forever_cpuclk);
    chk("rw_wrgnt", {87'd0, wr_gnt}, 88'd1);
    chk("rw_rdgnt", {87'd0, rd_gnt}, 88'd0);
    cyc();
    wr_req = 1'b0;
    @(negedge forever_cpuclk);
    chk("rw_rdgnt2", {87'd0, rd_gnt}, 88'd1);
    cyc();
    rd_req = 1'b0;
    @(negedge forever_cpuclk);
    chk("rw_vld",  {87'd0, rd_data_vld}, 88'd1);
    chk("rw_data", rd_data,              PAT3);
    cyc();

    // Partial mask write onto an all-ones entry
    do_wr(6'd7, 88'd0, 88'hFF);
    do_rd(6'd7, PART);

    // Invalidate-all from all-ones contents
    do_wr(6'd3, ONES, ONES);
    do_wr(6'd5, ONES, ONES);
    do_wr(6'd7, ONES, ONES);
    inv_all_req = 1'b1;
    rd_req = 1'b1; rd_idx = 6'd9;
    @(negedge forever_cpuclk);
    chk("invT_rdgnt", {87'd0, rd_gnt},   88'd1);
    chk("invT_busy",  {87'd0, inv_busy}, 88'd0);
    cyc();
    inv_all_req = 1'b0;
    rd_req = 1'b0;
    // A write held throughout the sweep must stay ungranted; mask 0 makes
    // its eventual grant harmless.
    wr_req = 1'b1; wr_idx = 6'd0; wr_data = 88'd0; wr_mask = 88'd0;
    for (int i = 0; i < 64; i++) begin
      inv_all_req = (i == 9);
      @(negedge forever_cpuclk);
      if (i == 0) begin
        chk("invT_vld",  {87'd0, rd_data_vld}, 88'd1);
        chk("invT_data", rd_data,              ONES);
      end
      chk($sformatf("sw%0d_busy", i),  {87'd0, inv_busy},  88'd1);
      chk($sformatf("sw%0d_a", i),     {82'd0, sram_a},    88'(i));
      chk($sformatf("sw%0d_wrgnt", i), {87'd0, wr_gnt},    88'd0);
      chk($sformatf("sw%0d_cen", i),   {87'd0, sram_cen},  88'd0);
      chk($sformatf("sw%0d_gwen", i),  {87'd0, sram_gwen}, 88'd0);
      chk($sformatf("sw%0d_wen", i),   sram_wen,           SWEN);
      chk($sformatf("sw%0d_d", i),     sram_d,             88'd0);
      chk($sformatf("sw%0d_done", i),  {87'd0, inv_done},  88'd0);
      cyc();
    end
    inv_all_req = 1'b0;
    @(negedge forever_cpuclk);
    chk("inv65_done",  {87'd0, inv_done}, 88'd1);
    chk("inv65_busy",  {87'd0, inv_busy}, 88'd0);
    chk("inv65_wrgnt", {87'd0, wr_gnt},   88'd1);
    cyc();
    wr_req = 1'b0;
    @(negedge forever_cpuclk);
    chk("inv66_done", {87'd0, inv_done}, 88'd0);
    chk("inv66_busy", {87'd0, inv_busy}, 88'd0);
    cyc();
    for (int i = 0; i < 64; i++) do_rd(6'(i), INVE);

    // Reset in the middle of a sweep
    fill_ones();
    inv_all_req = 1'b1;
    cyc();
    inv_all_req = 1'b0;
    repeat (20) cyc();
    @(negedge forever_cpuclk);
    chk("mid_a",    {82'd0, sram_a},   88'd20);
    chk("mid_busy", {87'd0, inv_busy}, 88'd1);
    #1 cpurst_b = 1'b0;
    #1;
    chk("mid_rst_busy", {87'd0, inv_busy}, 88'd0);
    cyc();
    cyc();
    chk("mid_rst_done", {87'd0, inv_done}, 88'd0);
    cpurst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge forever_cpuclk);
      chk($sformatf("mid_post%0d_done", k), {87'd0, inv_done}, 88'd0);
      chk($sformatf("mid_post%0d_busy", k), {87'd0, inv_busy}, 88'd0);
      cyc();
    end
    for (int i = 0; i < 64; i++) begin
      if (i < 20) do_rd(6'(i), INVE);
      else if (i > 20) do_rd(6'(i), ONES);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aq_mmu_tlbram_ctrl.md
# aq_mmu_tlbram_ctrl

Access controller sitting directly upstream of the 64-entry × 88-bit MMU TLB single-port SRAM. It arbitrates lookup reads, refill writes and an invalidate-all sweep onto the SRAM's one port. It drives the SRAM's active-low control pins and returns read data with a fixed 1-cycle latency. The SRAM instance lives outside this block; the parent wires this block's `sram_*` ports to it.

## Interface
- `ADDR_WIDTH`, 6, entry index width (64 entries).
- `DATA_WIDTH`, 88, entry width.
- `VLD_BIT`, 87, bit position of the entry valid flag; the only bit the sweep clears.

Ports:
- `forever_cpuclk`  in  1  clock; single clock domain.
- `cpurst_b`  in  1  asynchronous, active-low reset.
- `rd_req`  in  1  lookup read request.
- `rd_idx`  in  6  read entry index.
- `rd_gnt`  out  1  read accepted this cycle.
- `rd_data_vld`  out  1  `rd_data` valid this cycle.
- `rd_data`  out  88  read entry.
- `wr_req`  in  1  refill write request.
- `wr_idx`  in  6  write entry index.
- `wr_data`  in  88  write data.
- `wr_mask`  in  88  per-bit write enable, 1 = write.
- `wr_gnt`  out  1  write accepted this cycle.
- `inv_all_req`  in  1  invalidate-all pulse.
- `inv_busy`  out  1  sweep in progress.
- `inv_done`  out  1  one-cycle pulse at sweep completion.
- `sram_a`  out  6  SRAM address.
- `sram_cen`  out  1  SRAM chip enable, active low.
- `sram_gwen`  out  1  SRAM global write enable, active low.
- `sram_wen`  out  88  SRAM bit write enable, active low.
- `sram_d`  out  88  SRAM write data.
- `sram_q`  in  88  SRAM read data, valid the cycle after a read access.

## Operation
- FSM has two states: IDLE and INV. Reset state is IDLE.
- IDLE → INV on `inv_all_req`=1. INV → IDLE after the access at sweep index 63.
- Sweep counter is 6 bits. It is cleared on entry to INV and increments once per INV cycle.
- Port priority: INV sweep > write > read.
- In INV:
  - `rd_gnt`=`wr_gnt`=0.
  - SRAM access: `sram_cen`=0, `sram_gwen`=0, `sram_a`=counter, `sram_d`=0.
  - `sram_wen` is all ones except bit `VLD_BIT`=0, so only the valid flag is cleared.
- In IDLE with `wr_req`=1:
  - `wr_gnt`=1.
  - SRAM access: `sram_cen`=0, `sram_gwen`=0, `sram_a`=`wr_idx`, `sram_d`=`wr_data`, `sram_wen`=~`wr_mask`.
  - A read requested in the same cycle waits (`rd_gnt`=0).
- In IDLE with only `rd_req`=1:
  - `rd_gnt`=1.
  - SRAM access: `sram_cen`=0, `sram_gwen`=1, `sram_a`=`rd_idx`, `sram_wen` all ones.
- No request: `sram_cen`=1, `sram_gwen`=1, `sram_wen` all ones, `sram_a`/`sram_d`=0.
- Requesters hold `*_req` and their operands until they see the grant.
- `inv_all_req` while in INV is ignored; it is neither queued nor restarts the sweep.
- `rd_data`=`sram_q` combinationally. It is meaningful only while `rd_data_vld`=1.

## Timing
- Grants and `sram_*` outputs are combinational from the requests and registered state. The SRAM samples them at the next `forever_cpuclk` edge.
- Read granted in cycle N → `rd_data_vld`=1 in cycle N+1 (registered).
- A read in cycle N+1 at an index written in cycle N returns the new data.
- `inv_all_req` in cycle T (IDLE):
  - cycle T still serves rd/wr normally;
  - cycles T+1..T+64 sweep indices 0..63, with `inv_busy`=1;
  - cycle T+65: IDLE, `inv_busy`=0, `inv_done`=1 for exactly one cycle.
- Reset values: state IDLE, counter 0, `rd_data_vld`=0, `inv_busy`=0, `inv_done`=0.
- With no requests during reset: `sram_cen`=1, `sram_gwen`=1, `rd_gnt`=`wr_gnt`=0.
- Reset asserted mid-sweep aborts the sweep immediately and `inv_done` does not pulse. Entries already swept stay invalid; the owner reissues the invalidate.
- Counter wrap: the access at index 63 is the last sweep access. The counter returns to 0 with the transition to IDLE.

## Structure
- Shared MMU package holds:
  - `ADDR_WIDTH`, `DATA_WIDTH`, `VLD_BIT`;
  - the state encodings: IDLE=1'b0, INV=1'b1;
  - the sweep write-enable constant (all ones except `VLD_BIT`).
- No sub-module. The block is a single flat module with the FSM, sweep counter, arbitration mux and `rd_data_vld` flop.

## Test plan
- Write idx 5, data 88'hA5…, mask all ones, then read idx 5 → `wr_gnt` in cycle N; `rd_gnt` in N+1; `rd_data_vld`=1 with `rd_data`=88'hA5… in N+2.
- Read and write requested in the same cycle (idx 3 both) → `wr_gnt`=1, `rd_gnt`=0. Read granted the next cycle returns the written data.
- Partial mask: write 88'h0 with mask=88'hFF to an entry holding all ones → readback =88'hFF…FF00.
- Invalidate-all, starting from all entries all ones:
  - response: 64 sweep cycles with `inv_busy`=1 and grants blocked;
  - `inv_done` pulses at T+65;
  - every entry then reads back all ones except bit 87=0.
- Second `inv_all_req` at T+10 → ignored; `inv_done` still at T+65, exactly one pulse.
- Reset at sweep index 20 → `inv_busy`=0 and no `inv_done`; entries 0..19 invalid, 21..63 still valid after reset release. The entry at index 20 (the reset-cycle access) is not checked.
